// File: rtl/mc_ctrl_if.sv
// Control bundle between the multicycle controller and its datapath/memory.
// The controller side uses the master modport; the datapath side uses slave.
interface mc_ctrl_if #(
   parameter int unsigned ALUCTRL_W = 4
);
   logic [31:0]          instr;
   logic                 mem_ready;
   logic                 zero;
   logic                 pc_write;
   logic                 ir_write;
   logic                 mem_req;
   logic                 mem_we;
   logic                 reg_write;
   logic [ALUCTRL_W-1:0] alu_ctrl;
   logic                 alu_src;
   logic                 ext_ctrl;
   logic [1:0]           reg_dst;
   logic [1:0]           mem_to_reg;
   logic [1:0]           pc_src;
   logic [2:0]           state;
   logic                 illegal;
   logic                 bus_err;

   modport master (
      input  instr, mem_ready, zero,
      output pc_write, ir_write, mem_req, mem_we, reg_write,
      output alu_ctrl, alu_src, ext_ctrl, reg_dst, mem_to_reg, pc_src,
      output state, illegal, bus_err
   );

   modport slave (
      output instr, mem_ready, zero,
      input  pc_write, ir_write, mem_req, mem_we, reg_write,
      input  alu_ctrl, alu_src, ext_ctrl, reg_dst, mem_to_reg, pc_src,
      input  state, illegal, bus_err
   );
endinterface

// File: rtl/mc_ctrl.sv
// Multicycle MIPS-subset controller: FETCH/DECODE/EXEC/MEM/WB sequencing with
// memory-handshake timeout and a sticky error state.
module mc_ctrl #(
   parameter int unsigned ALUCTRL_W   = 4,
   parameter int unsigned MEM_TIMEOUT = 15
) (
   input logic       clk,
   input logic       rst_n,
   mc_ctrl_if.master bus
);

   typedef enum logic [2:0] {
      StFetch  = 3'd0,
      StDecode = 3'd1,
      StExec   = 3'd2,
      StMem    = 3'd3,
      StWb     = 3'd4,
      StErr    = 3'd7
   } state_e;

   typedef enum logic [3:0] {
      OpAdd, OpSub, OpJr, OpNop, OpOri, OpLw, OpSw, OpBeq, OpLui, OpJal, OpIll
   } op_e;

   localparam logic [7:0] TIMEOUT = 8'(MEM_TIMEOUT);

   state_e     state_q, state_d;
   logic [7:0] cnt_q, cnt_d;
   logic       illegal_q, illegal_d;
   logic       bus_err_q, bus_err_d;
   op_e        op;

   logic [5:0] opcode, funct;
   logic       unused_instr;

   logic                 pc_write, ir_write, mem_req, mem_we, reg_write;
   logic [ALUCTRL_W-1:0] alu_ctrl;
   logic                 alu_src, ext_ctrl;
   logic [1:0]           reg_dst, mem_to_reg, pc_src;

   assign opcode       = bus.instr[31:26];
   assign funct        = bus.instr[5:0];
   assign unused_instr = ^bus.instr[25:6];

   // Instruction class from opcode/funct; anything unlisted is illegal.
   always_comb begin
      op = OpIll;
      case (opcode)
         6'b000000: begin
            case (funct)
               6'b100000: op = OpAdd;
               6'b100010: op = OpSub;
               6'b001000: op = OpJr;
               6'b000000: op = OpNop;
               default:   op = OpIll;
            endcase
         end
         6'b001101: op = OpOri;
         6'b100011: op = OpLw;
         6'b101011: op = OpSw;
         6'b000100: op = OpBeq;
         6'b001111: op = OpLui;
         6'b000011: op = OpJal;
         default:   op = OpIll;
      endcase
   end

   // Next state, sticky flags and all control outputs.
   always_comb begin
      state_d    = state_q;
      illegal_d  = illegal_q;
      bus_err_d  = bus_err_q;
      pc_write   = 1'b0;
      ir_write   = 1'b0;
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      reg_write  = 1'b0;
      alu_ctrl   = '0;
      alu_src    = 1'b0;
      ext_ctrl   = 1'b0;
      reg_dst    = 2'd0;
      mem_to_reg = 2'd0;
      pc_src     = 2'd0;

      unique case (state_q)
         StFetch: begin
            mem_req = 1'b1;
            if (bus.mem_ready) begin
               ir_write = 1'b1;
               pc_write = 1'b1;
               state_d  = StDecode;
            end else if (cnt_q == TIMEOUT) begin
               bus_err_d = 1'b1;
               state_d   = StErr;
            end
         end
         StDecode: begin
            case (op)
               OpJal: begin
                  reg_write  = 1'b1;
                  reg_dst    = 2'd2;
                  mem_to_reg = 2'd2;
                  pc_write   = 1'b1;
                  pc_src     = 2'd2;
                  state_d    = StFetch;
               end
               OpJr: begin
                  pc_write = 1'b1;
                  pc_src   = 2'd3;
                  state_d  = StFetch;
               end
               OpNop:   state_d = StFetch;
               OpIll: begin
                  illegal_d = 1'b1;
                  state_d   = StErr;
               end
               default: state_d = StExec;
            endcase
         end
         StExec: begin
            case (op)
               OpBeq: begin
                  pc_write = bus.zero;
                  pc_src   = 2'd1;
                  state_d  = StFetch;
               end
               OpLw, OpSw: state_d = StMem;
               default:    state_d = StWb;
            endcase
         end
         StMem: begin
            mem_req = 1'b1;
            mem_we  = (op == OpSw);
            if (bus.mem_ready) begin
               state_d = (op == OpSw) ? StFetch : StWb;
            end else if (cnt_q == TIMEOUT) begin
               bus_err_d = 1'b1;
               state_d   = StErr;
            end
         end
         StWb: begin
            reg_write  = 1'b1;
            reg_dst    = (op == OpAdd || op == OpSub) ? 2'd1 : 2'd0;
            mem_to_reg = (op == OpLw) ? 2'd1 : 2'd0;
            state_d    = StFetch;
         end
         StErr: state_d = StErr;
         default: state_d = StFetch;
      endcase

      // ALU setup is held for the whole execute-to-writeback span of an instruction.
      if (state_q == StExec || state_q == StMem || state_q == StWb) begin
         case (op)
            OpAdd, OpLw, OpSw: alu_ctrl[3:0] = 4'b0010;
            OpSub, OpBeq:      alu_ctrl[3:0] = 4'b0110;
            OpOri:             alu_ctrl[3:0] = 4'b0001;
            OpLui:             alu_ctrl[3:0] = 4'b0011;
            default:           alu_ctrl[3:0] = 4'b0000;
         endcase
         alu_src  = (op == OpOri || op == OpLui || op == OpLw || op == OpSw);
         ext_ctrl = (op == OpOri || op == OpLui);
      end

      // Reset silences every output combinationally, without waiting for a clock.
      if (!rst_n) begin
         pc_write   = 1'b0;
         ir_write   = 1'b0;
         mem_req    = 1'b0;
         mem_we     = 1'b0;
         reg_write  = 1'b0;
         alu_ctrl   = '0;
         alu_src    = 1'b0;
         ext_ctrl   = 1'b0;
         reg_dst    = 2'd0;
         mem_to_reg = 2'd0;
         pc_src     = 2'd0;
      end
   end

   // Wait counter restarts on every state change and counts unanswered memory cycles.
   always_comb begin
      cnt_d = cnt_q;
      if (state_d != state_q) begin
         cnt_d = 8'd0;
      end else if ((state_q == StFetch || state_q == StMem) && !bus.mem_ready) begin
         cnt_d = cnt_q + 8'd1;
      end
   end

   // State, counter and sticky error flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StFetch;
         cnt_q     <= 8'd0;
         illegal_q <= 1'b0;
         bus_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         illegal_q <= illegal_d;
         bus_err_q <= bus_err_d;
      end
   end

   assign bus.pc_write   = pc_write;
   assign bus.ir_write   = ir_write;
   assign bus.mem_req    = mem_req;
   assign bus.mem_we     = mem_we;
   assign bus.reg_write  = reg_write;
   assign bus.alu_ctrl   = alu_ctrl;
   assign bus.alu_src    = alu_src;
   assign bus.ext_ctrl   = ext_ctrl;
   assign bus.reg_dst    = reg_dst;
   assign bus.mem_to_reg = mem_to_reg;
   assign bus.pc_src     = pc_src;
   assign bus.state      = state_q;
   assign bus.illegal    = illegal_q;
   assign bus.bus_err    = bus_err_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Randomized bench for mc_ctrl: a per-instruction model expands each
// instruction into its expected cycle-by-cycle output trace.
module tb_mc_ctrl;

   localparam int unsigned ALUCTRL_W   = 4;
   localparam int unsigned MEM_TIMEOUT = 15;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   mc_ctrl_if #(.ALUCTRL_W(ALUCTRL_W)) bus ();

   mc_ctrl #(
      .ALUCTRL_W  (ALUCTRL_W),
      .MEM_TIMEOUT(MEM_TIMEOUT)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   typedef enum {KAdd, KSub, KJr, KNop, KOri, KLw, KSw, KBeq, KLui, KJal, KIll} kind_e;

   typedef struct packed {
      logic [2:0] state;
      logic       pc_write;
      logic       ir_write;
      logic       mem_req;
      logic       mem_we;
      logic       reg_write;
      logic [3:0] alu_ctrl;
      logic       alu_src;
      logic       ext_ctrl;
      logic [1:0] reg_dst;
      logic [1:0] mem_to_reg;
      logic [1:0] pc_src;
      logic       illegal;
      logic       bus_err;
   } out_t;

   int   n_checks = 0;
   int   n_fail   = 0;
   int   zero_force = -1;
   out_t exp_q[$];
   logic rdy_q[$];
   logic zero_q[$];

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic out_t observe();
      out_t o;
      o.state      = bus.state;
      o.pc_write   = bus.pc_write;
      o.ir_write   = bus.ir_write;
      o.mem_req    = bus.mem_req;
      o.mem_we     = bus.mem_we;
      o.reg_write  = bus.reg_write;
      o.alu_ctrl   = bus.alu_ctrl[3:0];
      o.alu_src    = bus.alu_src;
      o.ext_ctrl   = bus.ext_ctrl;
      o.reg_dst    = bus.reg_dst;
      o.mem_to_reg = bus.mem_to_reg;
      o.pc_src     = bus.pc_src;
      o.illegal    = bus.illegal;
      o.bus_err    = bus.bus_err;
      return o;
   endfunction

   function automatic out_t base(input logic [2:0] st);
      out_t o = '0;
      o.state = st;
      return o;
   endfunction

   function automatic kind_e kind_of(input logic [31:0] ins);
      case (ins[31:26])
         6'h00: begin
            case (ins[5:0])
               6'h20:   return KAdd;
               6'h22:   return KSub;
               6'h08:   return KJr;
               6'h00:   return KNop;
               default: return KIll;
            endcase
         end
         6'h0D:   return KOri;
         6'h23:   return KLw;
         6'h2B:   return KSw;
         6'h04:   return KBeq;
         6'h0F:   return KLui;
         6'h03:   return KJal;
         default: return KIll;
      endcase
   endfunction

   task automatic push(input out_t o, input logic rdy, input logic z);
      exp_q.push_back(o);
      rdy_q.push_back(rdy);
      zero_q.push_back(z);
   endtask

   task automatic push_err(input bit ill, input bit berr);
      out_t o = base(3'd7);
      o.illegal = ill;
      o.bus_err = berr;
      for (int i = 0; i < 3; i++) push(o, 1'($urandom), 1'($urandom));
   endtask

   // A memory phase tolerates up to MEM_TIMEOUT unanswered cycles.
   task automatic mem_phase(input out_t busy, input out_t done, input int waits,
                            output bit timed_out);
      timed_out = 1'b0;
      for (int i = 0; i < waits && i <= int'(MEM_TIMEOUT); i++) push(busy, 1'b0, 1'($urandom));
      if (waits > int'(MEM_TIMEOUT)) begin
         timed_out = 1'b1;
         push_err(1'b0, 1'b1);
      end else begin
         push(done, 1'b1, 1'($urandom));
      end
   endtask

   // Expected trace for one instruction with fw/mw unanswered memory cycles.
   task automatic build(input logic [31:0] ins, input int fw, input int mw, output bit need_rst);
      kind_e k = kind_of(ins);
      out_t  o, d, alu;
      bit    to;
      logic  z;
      need_rst = 1'b0;
      alu = '0;
      case (k)
         KAdd, KLw, KSw: alu.alu_ctrl = 4'b0010;
         KSub, KBeq:     alu.alu_ctrl = 4'b0110;
         KOri:           alu.alu_ctrl = 4'b0001;
         KLui:           alu.alu_ctrl = 4'b0011;
         default:        alu.alu_ctrl = 4'b0000;
      endcase
      alu.alu_src  = (k inside {KOri, KLui, KLw, KSw});
      alu.ext_ctrl = (k inside {KOri, KLui});

      o = base(3'd0);
      o.mem_req = 1'b1;
      d = o;
      d.ir_write = 1'b1;
      d.pc_write = 1'b1;
      mem_phase(o, d, fw, to);
      if (to) begin
         need_rst = 1'b1;
         return;
      end

      o = base(3'd1);
      if (k == KJal) begin
         o.reg_write = 1'b1; o.reg_dst = 2'd2; o.mem_to_reg = 2'd2;
         o.pc_write = 1'b1; o.pc_src = 2'd2;
         push(o, 1'($urandom), 1'($urandom));
         return;
      end
      if (k == KJr) begin
         o.pc_write = 1'b1; o.pc_src = 2'd3;
         push(o, 1'($urandom), 1'($urandom));
         return;
      end
      push(o, 1'($urandom), 1'($urandom));
      if (k == KNop) return;
      if (k == KIll) begin
         push_err(1'b1, 1'b0);
         need_rst = 1'b1;
         return;
      end

      o = alu;
      o.state = 3'd2;
      if (k == KBeq) begin
         z = (zero_force < 0) ? 1'($urandom) : 1'(zero_force);
         o.pc_write = z;
         o.pc_src = 2'd1;
         push(o, 1'($urandom), z);
         return;
      end
      push(o, 1'($urandom), 1'($urandom));

      if (k == KLw || k == KSw) begin
         o = alu;
         o.state = 3'd3;
         o.mem_req = 1'b1;
         o.mem_we = (k == KSw);
         mem_phase(o, o, mw, to);
         if (to) begin
            need_rst = 1'b1;
            return;
         end
         if (k == KSw) return;
      end

      o = alu;
      o.state = 3'd4;
      o.reg_write = 1'b1;
      o.reg_dst = (k == KAdd || k == KSub) ? 2'd1 : 2'd0;
      o.mem_to_reg = (k == KLw) ? 2'd1 : 2'd0;
      push(o, 1'($urandom), 1'($urandom));
   endtask

   // Pulse reset away from the clock edge and check outputs collapse immediately.
   task automatic do_reset(input string tag);
      #1 rst_n = 1'b0;
      bus.mem_ready = 1'b0;
      #1 check_eq({tag, "/rst"}, 32'(observe()), 32'(base(3'd0)));
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Each iteration starts at a falling edge; outputs are sampled 1 unit later.
   task automatic run(input string tag, input logic [31:0] ins, input int fw, input int mw,
                      input int abort_at);
      bit need_rst;
      int ab = abort_at;
      exp_q.delete();
      rdy_q.delete();
      zero_q.delete();
      build(ins, fw, mw, need_rst);
      if (ab >= exp_q.size()) ab = -1;
      if (need_rst && ab < 0) ab = exp_q.size() - 1;
      bus.instr = ins;
      for (int i = 0; i < exp_q.size(); i++) begin
         bus.mem_ready = rdy_q[i];
         bus.zero = zero_q[i];
         #1 check_eq(tag, 32'(observe()), 32'(exp_q[i]));
         if (i == ab) begin
            do_reset(tag);
            return;
         end
         @(negedge clk);
      end
   endtask

   function automatic logic [31:0] rand_instr();
      logic [31:0] r = $urandom;
      logic [5:0]  f;
      case ($urandom_range(0, 11))
         0:  return {6'h00, r[25:6], 6'h20};
         1:  return {6'h00, r[25:6], 6'h22};
         2:  return {6'h00, r[25:6], 6'h08};
         3:  return {6'h00, r[25:6], 6'h00};
         4:  return {6'h0D, r[25:0]};
         5:  return {6'h23, r[25:0]};
         6:  return {6'h2B, r[25:0]};
         7:  return {6'h04, r[25:0]};
         8:  return {6'h0F, r[25:0]};
         9:  return {6'h03, r[25:0]};
         10: begin
            f = 6'($urandom);
            if (f inside {6'h20, 6'h22, 6'h08, 6'h00}) f = 6'h3F;
            return {6'h00, r[25:6], f};
         end
         default: begin
            f = 6'($urandom);
            if (f inside {6'h00, 6'h0D, 6'h23, 6'h2B, 6'h04, 6'h0F, 6'h03}) f = 6'h3F;
            return {f, r[25:0]};
         end
      endcase
   endfunction

   function automatic int rand_wait();
      if ($urandom_range(0, 9) == 0) return $urandom_range(MEM_TIMEOUT - 1, MEM_TIMEOUT + 2);
      return $urandom_range(0, 2);
   endfunction

   initial begin
      bus.instr     = 32'h0;
      bus.mem_ready = 1'b0;
      bus.zero      = 1'b0;
      #12 check_eq("reset", 32'(observe()), 32'(base(3'd0)));
      @(negedge clk);
      rst_n = 1'b1;

      run("add", 32'h00221820, 0, 0, -1);
      run("lw_wait3", 32'h8C220004, 0, 3, -1);
      zero_force = 1;
      run("beq_z1", 32'h10220003, 0, 0, -1);
      zero_force = 0;
      run("beq_z0", 32'h10220003, 0, 0, -1);
      zero_force = -1;
      run("jal", 32'h0C000010, 0, 0, -1);
      run("ill_3f", 32'hFC000000, 0, 0, -1);
      run("fetch_timeout", 32'h00221820, MEM_TIMEOUT + 1, 0, -1);
      run("fetch_last_wait", 32'h00221820, MEM_TIMEOUT, 0, -1);
      run("mem_timeout", 32'h8C220004, 0, MEM_TIMEOUT + 1, -1);
      run("mem_last_wait", 32'hAC220004, 0, MEM_TIMEOUT, -1);
      run("sw_abort", 32'hAC220004, 0, 0, 3);
      run("after_abort", 32'h35220055, 1, 0, -1);

      for (int n = 0; n < 400; n++) begin
         run("rand", rand_instr(), rand_wait(), rand_wait(),
             ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 7)) : -1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
